// File: rtl/gpio_stream_out.sv
// Streams 128-bit GPIO words out as 16 LSB-first bytes through a 2-entry FIFO with a ready/valid sink.
// Optional even-parity output enabled by defining GPIO_STREAM_PARITY_EN.
module gpio_stream_out (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] GPIO,
    input  logic         GPIOEnR,
    input  logic         GPIOEnG,
    input  logic         GPIOEnB,
    input  logic         GPIOEn,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    output logic [1:0]   out_chan,
    output logic         out_last,
    output logic         out_parity,
    output logic         busy,
    output logic         overflow
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [129:0]   ent_q [2];
    logic [129:0]   ent_d [2];
    logic [1:0]     count_q, count_d;
    logic [127:0]   sreg_q, sreg_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     out_data_q, out_data_d;
    logic [1:0]     out_chan_q, out_chan_d;
    logic           out_last_q, out_last_d;
    logic           out_valid_q, out_valid_d;
    logic           overflow_q, overflow_d;

    logic [1:0]     tag;
    logic [1:0]     count_after_pop;
    logic           xfer, last_xfer, pop, push;

    always_comb begin
        case ({GPIOEnR, GPIOEnG, GPIOEnB})
            3'b100:  tag = 2'd0;
            3'b010:  tag = 2'd1;
            3'b001:  tag = 2'd2;
            default: tag = 2'd3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ent_d       = ent_q;
        sreg_d      = sreg_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        xfer      = out_valid_q && out_ready;
        last_xfer = xfer && (idx_q == 4'd15);
        pop       = (count_q != 2'd0) && ((state_q == IDLE) || last_xfer);
        // A full FIFO still accepts a write when the head leaves at the same edge.
        push      = GPIOEn && ((count_q != 2'd2) || pop);

        count_after_pop = count_q - 2'(pop);
        count_d         = count_after_pop + 2'(push);
        overflow_d      = overflow_q | (GPIOEn && (count_q == 2'd2) && !pop);

        if (pop)
            ent_d[0] = ent_q[1];
        if (push)
            ent_d[count_after_pop[0]] = {tag, GPIO};

        if ((state_q == SEND) && xfer && (idx_q != 4'd15)) begin
            idx_d      = idx_q + 4'd1;
            sreg_d     = sreg_q >> 8;
            out_data_d = sreg_q[15:8];
            out_last_d = (idx_q == 4'd14);
        end

        if (pop) begin
            state_d     = SEND;
            sreg_d      = ent_q[0][127:0];
            idx_d       = '0;
            out_data_d  = ent_q[0][7:0];
            out_chan_d  = ent_q[0][129:128];
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
        end else if (last_xfer) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ent_q[0]    <= '0;
            ent_q[1]    <= '0;
            count_q     <= '0;
            sreg_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ent_q       <= ent_d;
            count_q     <= count_d;
            sreg_q      <= sreg_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = (count_q != 2'd0) || (state_q == SEND);

`ifdef GPIO_STREAM_PARITY_EN
    assign out_parity = out_valid_q & (^out_data_q);
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_stream_out.sv
// Scoreboard bench for gpio_stream_out: expected bytes queued at capture, compared on each transfer.
module tb_gpio_stream_out;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] gpio;
    logic         en_r, en_g, en_b, en;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic [1:0]   out_chan;
    logic         out_last;
    logic         out_parity;
    logic         busy;
    logic         overflow;

    int           checks = 0;
    int           errors = 0;
    int           xfers  = 0;
    logic [10:0]  sb [$];

    localparam logic [127:0] RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

    gpio_stream_out dut (
        .clk       (clk),
        .rst       (rst),
        .GPIO      (gpio),
        .GPIOEnR   (en_r),
        .GPIOEnG   (en_g),
        .GPIOEnB   (en_b),
        .GPIOEn    (en),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .out_parity(out_parity),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_tag(input logic rr, input logic gg, input logic bb);
        int n;
        n = int'(rr) + int'(gg) + int'(bb);
        if (n != 1) return 2'd3;
        if (rr) return 2'd0;
        if (gg) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic exp_par(input logic [7:0] d);
`ifdef GPIO_STREAM_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_word(input logic [127:0] w, input logic [1:0] t);
        for (int i = 0; i < 16; i++)
            sb.push_back({(i == 15), t, w[8*i +: 8]});
    endtask

    // One clock cycle; any transfer seen in it is popped from the scoreboard and compared.
    task automatic step();
        logic [10:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            xfers++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got data=%02h chan=%0d last=%0b, required no transfer",
                         out_data, out_chan, out_last);
            end else begin
                e = sb.pop_front();
                if ({out_last, out_chan, out_data} !== e) begin
                    errors++;
                    $display("FAIL sb_byte: got last=%0b chan=%0d data=%02h, required last=%0b chan=%0d data=%02h",
                             out_last, out_chan, out_data, e[10], e[9:8], e[7:0]);
                end
                checks++;
                if (out_parity !== exp_par(e[7:0])) begin
                    errors++;
                    $display("FAIL sb_parity: got %0b, required %0b", out_parity, exp_par(e[7:0]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [127:0] w, input logic rr, input logic gg, input logic bb,
                           input bit accept);
        gpio = w; en_r = rr; en_g = gg; en_b = bb; en = 1'b1;
        if (accept) push_word(w, exp_tag(rr, gg, bb));
        step();
        en = 1'b0; en_r = 1'b0; en_g = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        gpio = RAMP; en_r = 1'b1; en_g = 1'b0; en_b = 1'b0; en = 1'b1;
        step(); step();
        rst = 1'b0; en = 1'b0; en_r = 1'b0;
        checks += 7;
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %0b, required 0", out_valid); end
        if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %02h, required 00", out_data); end
        if (out_chan !== 2'd0)   begin errors++; $display("FAIL rst_chan: got %0d, required 0", out_chan); end
        if (out_last !== 1'b0)   begin errors++; $display("FAIL rst_last: got %0b, required 0", out_last); end
        if (out_parity !== 1'b0) begin errors++; $display("FAIL rst_parity: got %0b, required 0", out_parity); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
        if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %0b, required 0", overflow); end
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_ignore_en: got valid=%0b busy=%0b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1; xfers = 0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_c0: got valid=%0b, required 0", out_valid); end
        capture(RAMP, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_c1: got valid=%0b, required 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL single_c2: got valid=%0b data=%02h chan=%0d, required 1 00 0", out_valid, out_data, out_chan);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks += 3;
        if (sb.size() != 0) begin errors++; $display("FAIL single_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 16)    begin errors++; $display("FAIL single_count: got %0d, required 16", xfers); end
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h0F || busy !== 1'b0 || out_parity !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got valid=%0b last=%0b data=%02h busy=%0b par=%0b, required 0 0 0f 0 0",
                     out_valid, out_last, out_data, busy, out_parity);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; xfers = 0;
        capture(RAMP, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && xfers < 2; i++) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: got valid=%0b data=%02h last=%0b, required 1 02 0", out_valid, out_data, out_last);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 16)    begin errors++; $display("FAIL bp_count: got %0d, required 16", xfers); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; xfers = 0;
        capture(rand_word(), 1'b0, 1'b1, 1'b0, 1'b1);
        capture(rand_word(), 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap: got valid=%0b at byte %0d, required 1", out_valid, i); end
            step();
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 32)    begin errors++; $display("FAIL b2b_count: got %0d, required 32", xfers); end
    endtask

    task automatic test_tag();
        out_ready = 1'b1;
        capture(rand_word(), 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd3) begin
            errors++;
            $display("FAIL tag_rg: got valid=%0b chan=%0d, required 1 3", out_valid, out_chan);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL tag_drain: got %0d left, required 0", sb.size()); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1; xfers = 0;
        capture(rand_word(), 1'b1, 1'b0, 1'b0, 1'b1);
        capture(rand_word(), 1'b0, 1'b1, 1'b0, 1'b1);
        capture(rand_word(), 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40 && !(out_valid && out_last); i++) step();
        checks++;
        if (out_last !== 1'b1) begin errors++; $display("FAIL fullpop_last: got %0b, required 1", out_last); end
        capture(rand_word(), 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %0b, required 0", overflow); end
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL fullpop_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 64)    begin errors++; $display("FAIL fullpop_count: got %0d, required 64", xfers); end
    endtask

    task automatic test_overflow();
        logic [127:0] w1;
        out_ready = 1'b0; xfers = 0;
        w1 = rand_word();
        capture(w1, 1'b1, 1'b0, 1'b0, 1'b1);
        capture(rand_word(), 1'b0, 1'b1, 1'b0, 1'b1);
        capture(rand_word(), 1'b0, 1'b0, 1'b1, 1'b1);
        capture(rand_word(), 1'b1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got overflow=%0b busy=%0b, required 1 1", overflow, busy);
        end
        if (out_valid !== 1'b1 || out_data !== w1[7:0]) begin
            errors++;
            $display("FAIL ovf_head: got valid=%0b data=%02h, required 1 %02h", out_valid, out_data, w1[7:0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) step();
        step(); step(); step();
        checks += 3;
        if (sb.size() != 0) begin errors++; $display("FAIL ovf_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 48)    begin errors++; $display("FAIL ovf_count: got %0d, required 48", xfers); end
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got overflow=%0b valid=%0b, required 1 0", overflow, out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [127:0] w;
        out_ready = 1'b1; xfers = 0;
        capture(RAMP, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && xfers < 7; i++) step();
        checks++;
        if (out_data !== 8'h07 || out_parity !== exp_par(8'h07)) begin
            errors++;
            $display("FAIL par_07: got data=%02h parity=%0b, required 07 %0b", out_data, out_parity, exp_par(8'h07));
        end
        out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || out_last !== 1'b0 ||
            out_parity !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%0b d=%02h c=%0d l=%0b p=%0b busy=%0b ovf=%0b, required all 0",
                     out_valid, out_data, out_chan, out_last, out_parity, busy, overflow);
        end
        out_ready = 1'b1; xfers = 0;
        w = rand_word();
        capture(w, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== w[7:0]) begin
            errors++;
            $display("FAIL midrst_byte0: got valid=%0b data=%02h, required 1 %02h", out_valid, out_data, w[7:0]);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL midrst_drain: got %0d left, required 0", sb.size()); end
        if (xfers != 16)    begin errors++; $display("FAIL midrst_count: got %0d, required 16", xfers); end
    endtask

    initial begin
        rst = 1'b1; gpio = '0; en = 1'b0; en_r = 1'b0; en_g = 1'b0; en_b = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_tag();
        test_full_pop();
        test_overflow();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
